// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode/stat constants and hazard FSM state type
package y86_pkg;

    localparam int I_HALT   = 0;
    localparam int I_NOP    = 1;
    localparam int I_RRMOVQ = 2;
    localparam int I_IRMOVQ = 3;
    localparam int I_RMMOVQ = 4;
    localparam int I_MRMOVQ = 5;
    localparam int I_OPQ    = 6;
    localparam int I_JXX    = 7;
    localparam int I_CALL   = 8;
    localparam int I_RET    = 9;
    localparam int I_PUSHQ  = 10;
    localparam int I_POPQ   = 11;

    localparam int S_AOK = 1;
    localparam int S_HLT = 2;
    localparam int S_ADR = 3;
    localparam int S_INS = 4;

    // Register ID with every bit set means "no register"; width is applied by the user
    localparam int RNONE = -1;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_DRAIN,
        HZ_HALTED
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - Y86-64 stall/bubble control with exception drain FSM and perf counters
module pipe_hazard_ctrl
    import y86_pkg::*;
#(
    parameter int ICODE_W = 4,
    parameter int REG_W   = 4,
    parameter int STAT_W  = 4,
    parameter int PERF_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_destM,
    input  logic               e_cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    input  logic               mem_busy,
    input  logic               perf_clr,
    output logic               set_cc,
    output logic               F_stall,
    output logic               D_stall,
    output logic               E_stall,
    output logic               M_stall,
    output logic               W_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               W_bubble,
    output logic               halted,
    output logic [PERF_W-1:0]  cyc_cnt,
    output logic [PERF_W-1:0]  stall_cnt,
    output logic [PERF_W-1:0]  mispred_cnt
);

    localparam logic [REG_W-1:0] REG_NONE = REG_W'(RNONE);

    hz_state_t state;
    logic      exc_m, exc_w, lu, ret, mp;
    logic      frozen, drain_rule, normal_active;

    function automatic logic is_exc(input logic [STAT_W-1:0] s);
        return (s == STAT_W'(S_HLT)) || (s == STAT_W'(S_ADR)) || (s == STAT_W'(S_INS));
    endfunction

    assign exc_m = is_exc(m_stat);
    assign exc_w = is_exc(W_stat);
    assign lu    = ((E_icode == ICODE_W'(I_MRMOVQ)) || (E_icode == ICODE_W'(I_POPQ)))
                   && (E_destM != REG_NONE)
                   && ((E_destM == d_srcA) || (E_destM == d_srcB));
    assign ret   = (D_icode == ICODE_W'(I_RET)) || (E_icode == ICODE_W'(I_RET))
                   || (M_icode == ICODE_W'(I_RET));
    assign mp    = (E_icode == ICODE_W'(I_JXX)) && !e_cnd;

    assign frozen        = (state == HZ_HALTED) || exc_w;
    assign drain_rule    = (state == HZ_DRAIN) || exc_m;
    assign normal_active = rst_n && !frozen && !mem_busy;

    always_comb begin
        set_cc   = 1'b0;
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        E_stall  = 1'b0;
        M_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_bubble = 1'b0;
        if (!rst_n) begin
            set_cc = 1'b0;
        end else if (frozen) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
        end else if (mem_busy) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_stall  = 1'b1;
            M_stall  = 1'b1;
            W_bubble = 1'b1;
        end else begin
            F_stall  = lu || ret;
            D_stall  = lu;
            D_bubble = mp || (ret && !lu);
            E_bubble = mp || lu;
            M_bubble = drain_rule;
            // A bubbled E slot means the OPq there is not committing
            set_cc   = (E_icode == ICODE_W'(I_OPQ)) && !drain_rule && !(mp || lu);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= HZ_RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (exc_w) begin
                        state  <= HZ_HALTED;
                        halted <= 1'b1;
                    end else if (exc_m && !mem_busy) begin
                        state <= HZ_DRAIN;
                    end
                end
                HZ_DRAIN: begin
                    state  <= HZ_HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= HZ_HALTED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(PERF_W)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state != HZ_HALTED),
        .clr   (perf_clr),
        .cnt   (cyc_cnt)
    );

    sat_counter #(.W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (F_stall && (state != HZ_HALTED)),
        .clr   (perf_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(PERF_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mp && normal_active),
        .clr   (perf_clr),
        .cnt   (mispred_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] D_icode, E_icode, M_icode;
    logic [3:0] d_srcA, d_srcB, E_destM;
    logic       e_cnd;
    logic [3:0] m_stat, W_stat;
    logic       mem_busy, perf_clr;
    logic       set_cc, F_stall, D_stall, E_stall, M_stall, W_stall;
    logic       D_bubble, E_bubble, M_bubble, W_bubble, halted;
    logic [7:0] cyc_cnt, stall_cnt, mispred_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ICODE_W(4), .REG_W(4), .STAT_W(4), .PERF_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_destM(E_destM),
        .e_cnd(e_cnd), .m_stat(m_stat), .W_stat(W_stat),
        .mem_busy(mem_busy), .perf_clr(perf_clr),
        .set_cc(set_cc), .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall),
        .M_stall(M_stall), .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_bubble(W_bubble), .halted(halted),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
    );

    // {set_cc, F/D/E/M/W_stall, D/E/M/W_bubble, halted}
    localparam logic [10:0] C_NONE   = 11'b00000000000;
    localparam logic [10:0] C_LU     = 11'b01100001000;
    localparam logic [10:0] C_MPRET  = 11'b01000011000;
    localparam logic [10:0] C_RET    = 11'b01000010000;
    localparam logic [10:0] C_OPQ    = 11'b10000000000;
    localparam logic [10:0] C_BUSY   = 11'b01111000010;
    localparam logic [10:0] C_MP     = 11'b00000011000;
    localparam logic [10:0] C_DRAIN  = 11'b00000000100;
    localparam logic [10:0] C_WEXC   = 11'b01110100100;
    localparam logic [10:0] C_HALT   = 11'b01110100101;
    localparam logic [10:0] C_RSTHLT = 11'b00000000001;

    typedef struct {
        string      nm;
        logic [10:0] ctrl;
        bit         chk;
        logic [7:0] cyc;
        logic [7:0] stl;
        logic [7:0] mis;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic [10:0] act;

    task automatic idle();
        D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_destM = 4'hF;
        e_cnd = 1'b1; m_stat = 4'd1; W_stat = 4'd1;
        mem_busy = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [10:0] ec, input bit chk,
                         input int c, input int s, input int m);
        exp_t e;
        e.nm = nm; e.ctrl = ec; e.chk = chk;
        e.cyc = 8'(c); e.stl = 8'(s); e.mis = 8'(m);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            act = {set_cc, F_stall, D_stall, E_stall, M_stall, W_stall,
                   D_bubble, E_bubble, M_bubble, W_bubble, halted};
            checks++;
            if (act !== mon_e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl: got %b want %b", mon_e.nm, act, mon_e.ctrl);
            end
            if (mon_e.chk) begin
                checks += 3;
                if (cyc_cnt !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL %s cyc_cnt: got %0d want %0d", mon_e.nm, cyc_cnt, mon_e.cyc);
                end
                if (stall_cnt !== mon_e.stl) begin
                    errors++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", mon_e.nm, stall_cnt, mon_e.stl);
                end
                if (mispred_cnt !== mon_e.mis) begin
                    errors++;
                    $display("FAIL %s mispred_cnt: got %0d want %0d", mon_e.nm, mispred_cnt, mon_e.mis);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        E_icode = 4'd5; E_destM = 4'd3; d_srcA = 4'd3;
        issue("reset_ctrl", C_NONE, 1, 0, 0, 0);
        rst_n = 1'b1; idle();
        issue("idle", C_NONE, 1, 0, 0, 0);
        E_icode = 4'd5; E_destM = 4'd3; d_srcA = 4'd3;
        issue("load_use", C_LU, 1, 1, 0, 0);
        E_destM = 4'hF; d_srcB = 4'hF;
        issue("lu_rnone", C_NONE, 1, 2, 1, 0);
        idle(); E_icode = 4'd11; E_destM = 4'd4; d_srcB = 4'd4;
        issue("popq_lu_srcB", C_LU, 0, 0, 0, 0);
        idle(); E_icode = 4'd7; e_cnd = 1'b0; D_icode = 4'd9;
        issue("mp_ret", C_MPRET, 1, 4, 2, 0);
        idle(); M_icode = 4'd9;
        issue("ret_in_M", C_RET, 1, 5, 3, 1);
        idle(); E_icode = 4'd7;
        issue("jxx_taken", C_NONE, 0, 0, 0, 0);
        idle(); E_icode = 4'd6;
        issue("opq", C_OPQ, 0, 0, 0, 0);
        idle(); E_icode = 4'd5; E_destM = 4'd2; d_srcA = 4'd2; D_icode = 4'd9;
        issue("lu_and_ret", C_LU, 0, 0, 0, 0);

        idle(); E_icode = 4'd6; mem_busy = 1'b1;
        issue("busy1", C_BUSY, 0, 0, 0, 0);
        issue("busy2", C_BUSY, 0, 0, 0, 0);
        m_stat = 4'd3;
        issue("busy3_exc_ignored", C_BUSY, 0, 0, 0, 0);
        m_stat = 4'd1;
        issue("busy4", C_BUSY, 0, 0, 0, 0);
        mem_busy = 1'b0;
        issue("busy_release", C_OPQ, 1, 13, 9, 1);
        idle(); E_icode = 4'd7; e_cnd = 1'b0;
        issue("mp_only", C_MP, 0, 0, 0, 0);

        idle(); E_icode = 4'd6; m_stat = 4'd3;
        issue("exc_m", C_DRAIN, 1, 15, 9, 2);
        m_stat = 4'd1; W_stat = 4'd3;
        issue("drain_exc_w", C_WEXC, 0, 0, 0, 0);
        idle();
        issue("halted", C_HALT, 1, 17, 10, 2);
        E_icode = 4'd7; e_cnd = 1'b0; mem_busy = 1'b1;
        issue("halted_frozen", C_HALT, 1, 17, 10, 2);
        idle(); rst_n = 1'b0;
        issue("rst_in_halt", C_RSTHLT, 1, 17, 10, 2);
        rst_n = 1'b1;
        issue("after_rst", C_NONE, 1, 0, 0, 0);

        m_stat = 4'd4;
        issue("exc_ins", C_DRAIN, 0, 0, 0, 0);
        m_stat = 4'd1;
        issue("drain_auto", C_DRAIN, 0, 0, 0, 0);
        issue("halted_auto", C_HALT, 0, 0, 0, 0);
        rst_n = 1'b0;
        issue("rst_again", C_RSTHLT, 0, 0, 0, 0);

        rst_n = 1'b1; idle(); E_icode = 4'd7; e_cnd = 1'b0; D_icode = 4'd9;
        repeat (300) @(posedge clk);
        #1;
        issue("sat_hold", C_MPRET, 1, 255, 255, 255);
        perf_clr = 1'b1;
        issue("sat_clr_edge", C_MPRET, 1, 255, 255, 255);
        idle();
        issue("after_clr", C_NONE, 1, 0, 0, 0);
        issue("count_again", C_NONE, 1, 1, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
